// File: rtl/rc5_crypt_param.sv
// Parametrised RC5-style block cipher core: runtime-loaded key table, one half-round per clock.
// Optional RC5_DECRYPT_EN adds a decrypt port that runs the inverse cipher in the same cycle count.
module rc5_crypt_param #(
  parameter int W = 8,
  parameter int R = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*W-1:0]           in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*W-1:0]           out_data,
  input  logic                     key_we,
  input  logic [$clog2(2*R+2)-1:0] key_addr,
  input  logic [W-1:0]             key_data,
  output logic                     key_err,
  output logic                     busy
`ifdef RC5_DECRYPT_EN
  ,
  input  logic                     decrypt
`endif
);

  localparam int NKEY  = 2 * R + 2;
  localparam int KAW   = $clog2(NKEY);
  localparam int RW    = $clog2(W);
  localparam int HW    = $clog2(2 * R);
  localparam int HLAST = 2 * R - 1;

  typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [HW-1:0]    h_q, h_d;
  logic [W-1:0]     s_q [NKEY];
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [2*W-1:0]   out_data_q, out_data_d;
  logic             key_err_q, key_err_d;
  logic             busy_q, busy_d;
  logic             key_ok;
  logic             accept;
  logic [KAW-1:0]   kidx;
  logic [W-1:0]     s_h;

`ifdef RC5_DECRYPT_EN
  logic dec_q, dec_d;
`else
  logic dec_q;
  assign dec_q = 1'b0;
`endif

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [RW-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} << n;
    return t[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [RW-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} >> n;
    return t[W-1:0];
  endfunction

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign key_err   = key_err_q;
  assign busy      = busy_q;

  assign accept = in_valid & in_ready_q & (state_q == IDLE);
  assign key_ok = key_we & (state_q == IDLE) & ({1'b0, key_addr} < (KAW+1)'(NKEY));
  assign kidx   = KAW'(h_q) + KAW'(2);
  assign s_h    = s_q[kidx];

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    h_d         = h_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    key_err_d   = key_we & ~key_ok;
`ifdef RC5_DECRYPT_EN
    dec_d       = dec_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d = in_data[2*W-1:W];
          b_d = in_data[W-1:0];
`ifdef RC5_DECRYPT_EN
          dec_d = decrypt;
          if (decrypt) begin
            // Inverse skips the whitening step up front and applies it at the end.
            state_d = ROUND;
            h_d     = HW'(HLAST);
          end else begin
            state_d = INIT;
            h_d     = '0;
          end
`else
          state_d = INIT;
          h_d     = '0;
`endif
        end
      end
      INIT: begin
        if (dec_q) begin
          a_d         = a_q - s_q[0];
          b_d         = b_q - s_q[1];
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_data_d  = {a_d, b_d};
        end else begin
          a_d     = a_q + s_q[0];
          b_d     = b_q + s_q[1];
          h_d     = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (dec_q) begin
          if (h_q[0]) b_d = rotr(b_q - s_h, a_q[RW-1:0]) ^ a_q;
          else        a_d = rotr(a_q - s_h, b_q[RW-1:0]) ^ b_q;
          if (h_q == '0) state_d = INIT;
          else           h_d = h_q - HW'(1);
        end else begin
          if (h_q[0]) b_d = rotl(b_q ^ a_q, a_q[RW-1:0]) + s_h;
          else        a_d = rotl(a_q ^ b_q, b_q[RW-1:0]) + s_h;
          if (h_q == HW'(HLAST)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_data_d  = {a_d, b_d};
          end else begin
            h_d = h_q + HW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      h_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      key_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef RC5_DECRYPT_EN
      dec_q       <= 1'b0;
`endif
      for (int i = 0; i < NKEY; i++) s_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      h_q         <= h_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      key_err_q   <= key_err_d;
      busy_q      <= busy_d;
`ifdef RC5_DECRYPT_EN
      dec_q       <= dec_d;
`endif
      // Table write lands on the accepting edge, before INIT/ROUND read it.
      if (key_ok) s_q[key_addr] <= key_data;
    end
  end

endmodule

// File: tb/tb_rc5_crypt_param.sv
// Directed self-checking bench for rc5_crypt_param (W=8, R=1 main instance; R=2 instance for key range).
// Decrypt scenarios are compiled in when RC5_DECRYPT_EN is defined.
module tb_rc5_crypt_param;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        key_we;
  logic [1:0]  key_addr;
  logic [7:0]  key_data;
  logic        key_err;
  logic        busy;
`ifdef RC5_DECRYPT_EN
  logic        decrypt;
`endif

  logic        k2_we;
  logic [2:0]  k2_addr;
  logic        k2_err;
  logic        d2_in_ready, d2_out_valid, d2_busy;
  logic [15:0] d2_out_data;

  int checks = 0;
  int errors = 0;

  rc5_crypt_param #(.W(8), .R(1)) dut (
    .clock(clk), .reset(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .key_we(key_we), .key_addr(key_addr), .key_data(key_data),
    .key_err(key_err), .busy(busy)
`ifdef RC5_DECRYPT_EN
    , .decrypt(decrypt)
`endif
  );

  rc5_crypt_param #(.W(8), .R(2)) dut2 (
    .clock(clk), .reset(rst_n),
    .in_valid(1'b0), .in_ready(d2_in_ready), .in_data(16'h0000),
    .out_valid(d2_out_valid), .out_ready(1'b0), .out_data(d2_out_data),
    .key_we(k2_we), .key_addr(k2_addr), .key_data(8'h55),
    .key_err(k2_err), .busy(d2_busy)
`ifdef RC5_DECRYPT_EN
    , .decrypt(1'b0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key_write(input logic [1:0] a, input logic [7:0] d);
    key_we = 1'b1; key_addr = a; key_data = d;
    tick();
    key_we = 1'b0;
  endtask

  // Offers one block, waits for the result, optionally completes the output handshake.
  task automatic run_block(input logic [15:0] d, input bit dec, input bit take,
                           output logic [15:0] q, output int lat, output bit to,
                           output time t_acc);
    int n;
    in_valid = 1'b1; in_data = d;
`ifdef RC5_DECRYPT_EN
    decrypt = dec;
`endif
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    tick();
    t_acc = $time;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    to = !out_valid;
    q = out_data;
    if (take) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || key_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: valid=%b busy=%b err=%b want 0 0 0", out_valid, busy, key_err); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: in_ready=%b busy=%b want 1 0", in_ready, busy); end
  endtask

  task automatic test_key_load();
    logic [7:0] kv [4];
    kv[0] = 8'h20; kv[1] = 8'h10; kv[2] = 8'hFF; kv[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      key_write(2'(i), kv[i]);
      checks++; if (key_err !== 1'b0) begin errors++; $display("FAIL key_load_err[%0d]: got %b want 0", i, key_err); end
    end
  endtask

  task automatic test_encrypt();
    logic [15:0] q; int lat; bit to; time t;
    run_block(16'h0000, 1'b0, 1'b1, q, lat, to, t);
    checks++; if (to || q !== 16'h2F9E) begin errors++; $display("FAIL enc_0000: got %h (timeout=%0d) want 2F9E", q, to); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL enc_latency: got %0d want 4", lat); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL enc_handshake: valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_stall();
    logic [15:0] q; int lat; bit to; time t;
    int bad;
    run_block(16'h0102, 1'b0, 1'b0, q, lat, to, t);
    checks++; if (to || q !== 16'hCBCD) begin errors++; $display("FAIL enc_0102: got %h (timeout=%0d) want CBCD", q, to); end
    bad = 0;
    in_valid = 1'b1; in_data = 16'hAAAA;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hCBCD || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b data=%h in_ready=%b busy=%b want 1 CBCD 0 1",
                 i, out_valid, out_data, in_ready, busy);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_data !== 16'hCBCD || in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release: valid=%b data=%h in_ready=%b want 0 CBCD 1", out_valid, out_data, in_ready); end
  endtask

  task automatic test_key_err();
    logic [15:0] q; int lat; bit to; time t; int n;
    in_valid = 1'b1; in_data = 16'h0000;
    tick();
    in_valid = 1'b0;
    key_we = 1'b1; key_addr = 2'd2; key_data = 8'h00;
    tick();
    key_we = 1'b0;
    checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL key_err_busy_pulse: got %b want 1", key_err); end
    tick();
    checks++; if (key_err !== 1'b0) begin errors++; $display("FAIL key_err_busy_width: got %b want 0", key_err); end
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h2F9E) begin
      errors++; $display("FAIL key_err_busy_result: valid=%b data=%h want 1 2F9E", out_valid, out_data); end
    key_we = 1'b1; key_addr = 2'd3; key_data = 8'h00;
    tick();
    key_we = 1'b0;
    checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL key_err_done_pulse: got %b want 1", key_err); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (key_err !== 1'b0) begin errors++; $display("FAIL key_err_done_width: got %b want 0", key_err); end
    run_block(16'h0000, 1'b0, 1'b1, q, lat, to, t);
    checks++; if (to || q !== 16'h2F9E) begin errors++; $display("FAIL key_table_kept: got %h want 2F9E", q); end
    // Wider table instance: indices 6,7 are out of range, 5 is the last valid slot.
    k2_we = 1'b1; k2_addr = 3'd6;
    tick();
    k2_we = 1'b0;
    checks++; if (k2_err !== 1'b1) begin errors++; $display("FAIL key_err_range: got %b want 1", k2_err); end
    k2_we = 1'b1; k2_addr = 3'd5;
    tick();
    k2_we = 1'b0;
    checks++; if (k2_err !== 1'b0) begin errors++; $display("FAIL key_ok_last: got %b want 0", k2_err); end
  endtask

  task automatic test_same_edge();
    int n;
    in_valid = 1'b1; in_data = 16'h0000;
`ifdef RC5_DECRYPT_EN
    decrypt = 1'b0;
`endif
    key_we = 1'b1; key_addr = 2'd2; key_data = 8'h00;
    tick();
    in_valid = 1'b0; key_we = 1'b0;
    checks++; if (key_err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL same_edge_accept: err=%b busy=%b want 0 1", key_err, busy); end
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h301F) begin
      errors++; $display("FAIL same_edge_result: valid=%b data=%h want 1 301F", out_valid, out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    key_write(2'd2, 8'hFF);
  endtask

  task automatic test_back_to_back();
    logic [15:0] q0, q1; int lat; bit to0, to1; time t0, t1;
    run_block(16'h0000, 1'b0, 1'b1, q0, lat, to0, t0);
    run_block(16'h0102, 1'b0, 1'b1, q1, lat, to1, t1);
    checks++; if (to0 || to1 || q0 !== 16'h2F9E || q1 !== 16'hCBCD) begin
      errors++; $display("FAIL b2b_results: got %h %h want 2F9E CBCD", q0, q1); end
    checks++; if (t1 - t0 !== 50) begin errors++; $display("FAIL b2b_period: got %0t want 50", t1 - t0); end
  endtask

`ifdef RC5_DECRYPT_EN
  task automatic test_decrypt();
    logic [15:0] q0, q1, q2; int lat; bit to0, to1, to2; time t0, t1, t2;
    run_block(16'h2F9E, 1'b1, 1'b1, q0, lat, to0, t0);
    checks++; if (to0 || q0 !== 16'h0000) begin errors++; $display("FAIL dec_2F9E: got %h want 0000", q0); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL dec_latency: got %0d want 4", lat); end
    run_block(16'h0102, 1'b0, 1'b1, q1, lat, to1, t1);
    run_block(16'hCBCD, 1'b1, 1'b1, q2, lat, to2, t2);
    checks++; if (to1 || to2 || q1 !== 16'hCBCD || q2 !== 16'h0102) begin
      errors++; $display("FAIL enc_dec_b2b: got %h %h want CBCD 0102", q1, q2); end
    checks++; if (t2 - t1 !== 50) begin errors++; $display("FAIL enc_dec_period: got %0t want 50", t2 - t1); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [15:0] q; int lat; bit to; time t;
    in_valid = 1'b1; in_data = 16'h0102;
`ifdef RC5_DECRYPT_EN
    decrypt = 1'b0;
`endif
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mid_abort: valid=%b busy=%b in_ready=%b want 0 0 0", out_valid, busy, in_ready); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_release: valid=%b busy=%b in_ready=%b want 0 0 1", out_valid, busy, in_ready); end
    run_block(16'h0000, 1'b0, 1'b1, q, lat, to, t);
    checks++; if (to || q !== 16'h0000) begin errors++; $display("FAIL reset_mid_table_cleared: got %h want 0000", q); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    key_we = 1'b0; key_addr = '0; key_data = '0;
    k2_we = 1'b0; k2_addr = '0;
`ifdef RC5_DECRYPT_EN
    decrypt = 1'b0;
`endif
    test_reset();
    test_key_load();
    test_encrypt();
    test_stall();
    test_key_err();
    test_same_edge();
    test_back_to_back();
`ifdef RC5_DECRYPT_EN
    test_decrypt();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
